// File: rtl/nbit_accumulator.sv
// ============================================================================
// Module   : nbit_accumulator
// Purpose  : Sums a frame of N-bit operands from a valid/ready stream into a
//            W = N+G bit accumulator and presents total, word count and a
//            sticky overflow flag on a held output handshake.
// Options  : ACC_SATURATE_EN - saturate the accumulator on carry out instead
//            of wrapping modulo 2^W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbit_accumulator #(
   parameter int N       = 4,
   parameter int G       = 4,
   parameter int MAX_LEN = 16,
   localparam int W      = N + G,
   localparam int CW     = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_sum,
   output logic [CW-1:0] out_count,
   output logic          out_ovf
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q,   acc_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            ovf_q,   ovf_d;
   logic [W-1:0]    sum_q,   sum_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovfo_q,  ovfo_d;

   logic            in_xfer;
   logic            frame_close;
   logic [W:0]      add_full;
   logic [W-1:0]    acc_add;
   logic [CW-1:0]   cnt_inc;

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign out_ovf   = ovfo_q;

   assign in_xfer  = in_valid & in_ready;
   assign add_full = {1'b0, acc_q} + {{(G + 1){1'b0}}, in_data};
   assign cnt_inc  = cnt_q + ONE_CNT;

`ifdef ACC_SATURATE_EN
   // Once pinned at all-ones any non-zero addend carries again, so it stays there.
   assign acc_add = add_full[W] ? {W{1'b1}} : add_full[W-1:0];
`else
   assign acc_add = add_full[W-1:0];
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sum_d       = sum_q;
      count_d     = count_q;
      ovfo_d      = ovfo_q;
      frame_close = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               acc_d = {{G{1'b0}}, in_data};
               cnt_d = ONE_CNT;
               ovf_d = 1'b0;
               if (in_last || (MAX_LEN == 1)) begin
                  frame_close = 1'b1;
               end else begin
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            if (in_xfer) begin
               acc_d = acc_add;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_full[W];
               if (in_last || (cnt_inc == MAX_CNT)) begin
                  frame_close = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Result registers capture the post-transfer totals so DONE shows them at once.
      if (frame_close) begin
         state_d = DONE;
         sum_d   = acc_d;
         count_d = cnt_d;
         ovfo_d  = ovf_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         ovfo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         ovfo_q  <= ovfo_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nbit_accumulator.sv
// ============================================================================
// Module   : tb_nbit_accumulator
// Purpose  : Scoreboard bench for nbit_accumulator; instance A uses defaults
//            (W=8), instance B uses G=2 (W=6) for the overflow cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nbit_accumulator;

   typedef struct packed {
      logic [31:0] sum;
      logic [31:0] cnt;
      logic        ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;

   logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
   logic [3:0] a_in_data;
   logic [7:0] a_out_sum;
   logic [4:0] a_out_count;

   logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
   logic [3:0] b_in_data;
   logic [5:0] b_out_sum;
   logic [4:0] b_out_count;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t qa[$];
   exp_t qb[$];
   int   ma_tot, ma_cnt, mb_tot, mb_cnt;
   logic a_seen = 1'b0;
   logic b_seen = 1'b0;

   always #5 clk = ~clk;

   nbit_accumulator #(.N(4), .G(4), .MAX_LEN(16)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_last   (a_in_last),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_sum   (a_out_sum),
      .out_count (a_out_count),
      .out_ovf   (a_out_ovf)
   );

   nbit_accumulator #(.N(4), .G(2), .MAX_LEN(16)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_sum   (b_out_sum),
      .out_count (b_out_count),
      .out_ovf   (b_out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference result from the integer frame total: any total above 2^w-1 means a carry happened.
   function automatic exp_t mk(input int tot, input int cnt, input int w);
      exp_t e;
      int   maxv;
      maxv  = (1 << w) - 1;
      e.ovf = (tot > maxv);
`ifdef ACC_SATURATE_EN
      e.sum = e.ovf ? maxv : tot;
`else
      e.sum = tot & maxv;
`endif
      e.cnt = cnt;
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      int ta, ca, tb, cb;
      if (rst) begin
         ma_tot <= 0; ma_cnt <= 0; mb_tot <= 0; mb_cnt <= 0;
      end else begin
         if (a_in_valid && a_in_ready) begin
            ta = ma_tot + int'(a_in_data);
            ca = ma_cnt + 1;
            if (a_in_last || ca == 16) begin
               qa.push_back(mk(ta, ca, 8));
               ta = 0; ca = 0;
            end
            ma_tot <= ta; ma_cnt <= ca;
         end
         if (b_in_valid && b_in_ready) begin
            tb = mb_tot + int'(b_in_data);
            cb = mb_cnt + 1;
            if (b_in_last || cb == 16) begin
               qb.push_back(mk(tb, cb, 6));
               tb = 0; cb = 0;
            end
            mb_tot <= tb; mb_cnt <= cb;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (a_out_valid && !a_seen) begin
         a_seen <= 1'b1;
         if (qa.size() == 0) check("a_unexpected_result", 1, 0);
         else begin
            e = qa.pop_front();
            check("a_sum", a_out_sum, e.sum);
            check("a_count", a_out_count, e.cnt);
            check("a_ovf", a_out_ovf, e.ovf);
         end
      end
      if (!a_out_valid) a_seen <= 1'b0;
      if (b_out_valid && !b_seen) begin
         b_seen <= 1'b1;
         if (qb.size() == 0) check("b_unexpected_result", 1, 0);
         else begin
            e = qb.pop_front();
            check("b_sum", b_out_sum, e.sum);
            check("b_count", b_out_count, e.cnt);
            check("b_ovf", b_out_ovf, e.ovf);
         end
      end
      if (!b_out_valid) b_seen <= 1'b0;
   end

   // Called #1 after a rising edge; returns #1 after the edge that took the word.
   task automatic send(input int sel, input logic [3:0] d, input logic last, input int gap);
      logic rdy;
      int   n;
      n = 0;
      if (sel == 0) begin a_in_valid = 1'b1; a_in_data = d; a_in_last = last; end
      else          begin b_in_valid = 1'b1; b_in_data = d; b_in_last = last; end
      forever begin
         @(negedge clk);
         rdy = (sel == 0) ? a_in_ready : b_in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 50) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      a_in_valid = 1'b0; a_in_last = 1'b0;
      b_in_valid = 1'b0; b_in_last = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
      #2;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_sum", a_out_sum, 0);
      check("rst_out_count", a_out_count, 0);
      check("rst_out_ovf", a_out_ovf, 0);
      check("rst_in_ready", a_in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic frame and one-cycle result latency
      send(0, 4'd3, 1'b0, 0);
      send(0, 4'd5, 1'b0, 0);
      check("t1_valid_early", a_out_valid, 0);
      send(0, 4'd7, 1'b1, 0);
      check("t1_latency_valid", a_out_valid, 1);
      check("t1_sum", a_out_sum, 15);
      check("t1_count", a_out_count, 3);
      check("t1_ovf", a_out_ovf, 0);

      // MAX_LEN closes the frame without in_last
      for (int i = 0; i < 16; i++) send(0, 4'd15, 1'b0, 0);
      check("t2_valid", a_out_valid, 1);
      check("t2_sum", a_out_sum, 240);
      check("t2_count", a_out_count, 16);

      // Overflow on the narrow accumulator
      for (int i = 0; i < 5; i++) send(1, 4'd15, (i == 4), 0);
      check("t3_valid", b_out_valid, 1);
`ifdef ACC_SATURATE_EN
      check("t3_sum", b_out_sum, 63);
`else
      check("t3_sum", b_out_sum, 11);
`endif
      check("t3_ovf", b_out_ovf, 1);
      check("t3_count", b_out_count, 5);

      // Held result under back-pressure, then the stalled word enters the next frame
      a_out_ready = 1'b0;
      send(0, 4'd3, 1'b0, 0);
      send(0, 4'd5, 1'b0, 0);
      send(0, 4'd7, 1'b1, 0);
      a_in_valid = 1'b1; a_in_data = 4'd9; a_in_last = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_valid", a_out_valid, 1);
         check("t4_hold_sum", a_out_sum, 15);
         check("t4_hold_count", a_out_count, 3);
         check("t4_hold_in_ready", a_in_ready, 0);
      end
      @(posedge clk);
      #1 a_out_ready = 1'b1;
      @(posedge clk);
      #1 a_out_ready = 1'b0;
      check("t4_idle_in_ready", a_in_ready, 1);
      check("t4_idle_valid", a_out_valid, 0);
      check("t4_idle_sum_kept", a_out_sum, 15);
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      check("t4_acc_valid", a_out_valid, 0);
      a_out_ready = 1'b1;
      send(0, 4'd1, 1'b1, 0);
      check("t4_next_sum", a_out_sum, 10);
      check("t4_next_count", a_out_count, 2);

      // Asynchronous reset mid-frame
      send(0, 4'd1, 1'b0, 0);
      send(0, 4'd2, 1'b0, 0);
      rst = 1'b1;
      #1;
      check("t5_async_sum", a_out_sum, 0);
      check("t5_async_count", a_out_count, 0);
      check("t5_async_valid", a_out_valid, 0);
      check("t5_async_b_sum", b_out_sum, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(0, 4'd9, 1'b1, 0);
      check("t5_sum", a_out_sum, 9);
      check("t5_count", a_out_count, 1);

      // Gaps between words
      send(0, 4'd1, 1'b0, $urandom_range(0, 3));
      send(0, 4'd2, 1'b0, $urandom_range(0, 3));
      send(0, 4'd4, 1'b1, 0);
      check("t6_sum", a_out_sum, 7);
      check("t6_count", a_out_count, 3);

      // Random frames, some longer than MAX_LEN
      for (int f = 0; f < 12; f++) begin
         len = $urandom_range(1, 20);
         for (int w = 0; w < len; w++) begin
            send(f % 2, 4'($urandom_range(0, 15)), (w == len - 1), $urandom_range(0, 2));
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("a_scoreboard_empty", qa.size(), 0);
      check("b_scoreboard_empty", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
